// File: rtl/esm_index_scheduler.sv
// Index sequencing controller for the ESM mapping table: fetches a random word, commits the
// table's selection as the active buffer index, keeps a two-deep history. Option: ESM_DWELL_EN.
module esm_index_scheduler #(
  parameter int BS      = 16,
  parameter int DWELL   = 8,
  parameter int TIMEOUT = 32,
  localparam int IW     = $clog2(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          advance_req,
  input  logic          rng_valid,
  input  logic [31:0]   rng_data,
  output logic          rng_ready,
  output logic [31:0]   random_number,
  input  logic [IW-1:0] tbl_next_index,
  input  logic          tbl_valid_count,
  output logic [IW-1:0] buffer_index,
  output logic [IW-1:0] buffer_index_sync_1,
  output logic [IW-1:0] buffer_index_sync_2,
  output logic          proceed,
  output logic          switch_pulse,
  output logic          busy,
  output logic          stall_err
);

  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_EVAL,
    ST_DWELL
  } state_t;

  state_t        state, state_next;
  logic          accept;
  logic          commit;
  logic          empty_eval;
  logic          start_idle;
  logic          dwell_done;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_inc;

`ifdef ESM_DWELL_EN
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DW-1:0] dwell_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (commit) begin
      dwell_cnt <= DW'(DWELL - 1);
    end else if (state == ST_DWELL && dwell_cnt != '0) begin
      dwell_cnt <= dwell_cnt - 1'b1;
    end
  end

  assign dwell_done = (dwell_cnt == '0);
`else
  logic dwell_unused;
  assign dwell_unused = (DWELL > 0);
  assign dwell_done   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // stop overrides every transition, which also suppresses a pending accept or commit
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    empty_eval = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_next = ST_FETCH;
        ST_FETCH: begin
          if (rng_valid && rng_ready) begin
            accept     = 1'b1;
            state_next = ST_SETTLE;
          end
        end
        ST_SETTLE: state_next = ST_EVAL;
        ST_EVAL: begin
          if (tbl_valid_count) begin
            commit     = 1'b1;
            state_next = ST_DWELL;
          end else begin
            empty_eval = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_DWELL:  if (dwell_done && advance_req) state_next = ST_FETCH;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  assign start_idle = (state == ST_IDLE) && start;
  assign starve_inc = (starve_cnt == SW'(TIMEOUT)) ? starve_cnt : starve_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_err  <= 1'b0;
    end else begin
      if (commit || start_idle) begin
        starve_cnt <= '0;
      end else if (empty_eval) begin
        starve_cnt <= starve_inc;
      end
      if (start_idle) begin
        stall_err <= 1'b0;
      end else if (empty_eval && starve_inc == SW'(TIMEOUT)) begin
        stall_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_number       <= '0;
      buffer_index        <= '0;
      buffer_index_sync_1 <= '0;
      buffer_index_sync_2 <= '0;
    end else begin
      if (accept) random_number <= rng_data;
      if (commit) begin
        buffer_index_sync_2 <= buffer_index_sync_1;
        buffer_index_sync_1 <= buffer_index;
        buffer_index        <= tbl_next_index;
      end
    end
  end

  // Status flags are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rng_ready    <= 1'b0;
      proceed      <= 1'b0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      rng_ready    <= (state_next == ST_FETCH);
      proceed      <= (state_next == ST_DWELL);
      busy         <= (state_next != ST_IDLE);
      switch_pulse <= commit;
    end
  end

endmodule

// File: tb/tb_esm_index_scheduler.sv
// Directed self-checking bench for esm_index_scheduler (BS=16, DWELL=8, TIMEOUT=4).
module tb_esm_index_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        advance_req;
  logic        rng_valid;
  logic [31:0] rng_data;
  logic        rng_ready;
  logic [31:0] random_number;
  logic [3:0]  tbl_next_index;
  logic        tbl_valid_count;
  logic [3:0]  buffer_index;
  logic [3:0]  buffer_index_sync_1;
  logic [3:0]  buffer_index_sync_2;
  logic        proceed;
  logic        switch_pulse;
  logic        busy;
  logic        stall_err;

  int checks   = 0;
  int failures = 0;

`ifdef ESM_DWELL_EN
  localparam int EXP_DWELL_LAT = 8;
`else
  localparam int EXP_DWELL_LAT = 1;
`endif

  esm_index_scheduler #(.BS(16), .DWELL(8), .TIMEOUT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .stop                (stop),
    .advance_req         (advance_req),
    .rng_valid           (rng_valid),
    .rng_data            (rng_data),
    .rng_ready           (rng_ready),
    .random_number       (random_number),
    .tbl_next_index      (tbl_next_index),
    .tbl_valid_count     (tbl_valid_count),
    .buffer_index        (buffer_index),
    .buffer_index_sync_1 (buffer_index_sync_1),
    .buffer_index_sync_2 (buffer_index_sync_2),
    .proceed             (proceed),
    .switch_pulse        (switch_pulse),
    .busy                (busy),
    .stall_err           (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: handshake, SETTLE, EVAL, commit; returns just after the commit edge
  task automatic do_commit(input logic [3:0] idx, input logic [31:0] data);
    rng_data        = data;
    rng_valid       = 1'b1;
    tbl_valid_count = 1'b1;
    tbl_next_index  = idx;
    tick();
    rng_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic go_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (rng_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_rng_ready got=%0b exp=0", rng_ready); end
    checks++; if (buffer_index !== 4'd0) begin failures++; $display("[TB] FAIL reset_index got=%0d exp=0", buffer_index); end
    checks++; if (random_number !== 32'd0) begin failures++; $display("[TB] FAIL reset_random got=%0h exp=0", random_number); end
    checks++; if (stall_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall_err); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_hold_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_first_commit();
    go_fetch();
    checks++; if (rng_ready !== 1'b1) begin failures++; $display("[TB] FAIL start_rng_ready got=%0b exp=1", rng_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL start_busy got=%0b exp=1", busy); end
    rng_data        = 32'h0000_0003;
    rng_valid       = 1'b1;
    tbl_valid_count = 1'b1;
    tbl_next_index  = 4'd9;
    tick();
    rng_valid = 1'b0;
    checks++; if (random_number !== 32'h3) begin failures++; $display("[TB] FAIL latch_random got=%0h exp=3", random_number); end
    checks++; if (rng_ready !== 1'b0) begin failures++; $display("[TB] FAIL settle_rng_ready got=%0b exp=0", rng_ready); end
    tick();
    checks++; if (buffer_index !== 4'd0) begin failures++; $display("[TB] FAIL early_commit got=%0d exp=0", buffer_index); end
    checks++; if (switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL early_pulse got=%0b exp=0", switch_pulse); end
    tick();
    checks++; if (buffer_index !== 4'd9) begin failures++; $display("[TB] FAIL commit_index got=%0d exp=9", buffer_index); end
    checks++; if (buffer_index_sync_1 !== 4'd0) begin failures++; $display("[TB] FAIL commit_sync1 got=%0d exp=0", buffer_index_sync_1); end
    checks++; if (buffer_index_sync_2 !== 4'd0) begin failures++; $display("[TB] FAIL commit_sync2 got=%0d exp=0", buffer_index_sync_2); end
    checks++; if (switch_pulse !== 1'b1) begin failures++; $display("[TB] FAIL pulse_high got=%0b exp=1", switch_pulse); end
    checks++; if (proceed !== 1'b1) begin failures++; $display("[TB] FAIL proceed_rise got=%0b exp=1", proceed); end
    tick();
    checks++; if (switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL pulse_width got=%0b exp=0", switch_pulse); end
    checks++; if (proceed !== 1'b1) begin failures++; $display("[TB] FAIL proceed_hold got=%0b exp=1", proceed); end
  endtask

  task automatic test_history();
    logic [3:0] sel [2];
    int n;
    sel[0] = 4'd4;
    sel[1] = 4'd12;
    for (int k = 0; k < 2; k++) begin
      advance_req = 1'b1;
      n = 0;
      while (rng_ready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      advance_req = 1'b0;
      checks++; if (rng_ready !== 1'b1) begin failures++; $display("[TB] FAIL history_wait_ready got=%0b exp=1", rng_ready); end
      do_commit(sel[k], 32'h100 + k);
    end
    checks++; if (buffer_index !== 4'd12) begin failures++; $display("[TB] FAIL history_index got=%0d exp=12", buffer_index); end
    checks++; if (buffer_index_sync_1 !== 4'd4) begin failures++; $display("[TB] FAIL history_sync1 got=%0d exp=4", buffer_index_sync_1); end
    checks++; if (buffer_index_sync_2 !== 4'd9) begin failures++; $display("[TB] FAIL history_sync2 got=%0d exp=9", buffer_index_sync_2); end
  endtask

  task automatic test_dwell_timing();
    int n;
    advance_req = 1'b1;
    n = 0;
    while (rng_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    advance_req = 1'b0;
    checks++; if (n !== EXP_DWELL_LAT) begin failures++; $display("[TB] FAIL dwell_latency got=%0d exp=%0d", n, EXP_DWELL_LAT); end
    checks++; if (proceed !== 1'b0) begin failures++; $display("[TB] FAIL dwell_proceed_drop got=%0b exp=0", proceed); end
  endtask

  task automatic test_stall();
    tbl_valid_count = 1'b0;
    rng_valid       = 1'b1;
    rng_data        = 32'hABCD_0001;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (stall_err !== 1'b0) begin failures++; $display("[TB] FAIL stall_early got=%0b exp=0", stall_err); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_err !== 1'b1) begin failures++; $display("[TB] FAIL stall_set got=%0b exp=1", stall_err); end
    checks++; if (buffer_index !== 4'd12) begin failures++; $display("[TB] FAIL stall_index got=%0d exp=12", buffer_index); end
    checks++; if (buffer_index_sync_1 !== 4'd4) begin failures++; $display("[TB] FAIL stall_sync1 got=%0d exp=4", buffer_index_sync_1); end
    checks++; if (rng_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_retry_ready got=%0b exp=1", rng_ready); end
    rng_valid = 1'b0;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_idle got=%0b exp=0", busy); end
    checks++; if (stall_err !== 1'b1) begin failures++; $display("[TB] FAIL stall_sticky got=%0b exp=1", stall_err); end
    go_fetch();
    checks++; if (stall_err !== 1'b0) begin failures++; $display("[TB] FAIL stall_clear got=%0b exp=0", stall_err); end
    checks++; if (rng_ready !== 1'b1) begin failures++; $display("[TB] FAIL restart_ready got=%0b exp=1", rng_ready); end
  endtask

  task automatic test_stop_eval();
    rng_data        = 32'h0000_0055;
    rng_valid       = 1'b1;
    tbl_valid_count = 1'b1;
    tbl_next_index  = 4'd7;
    tick();
    rng_valid = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (buffer_index !== 4'd12) begin failures++; $display("[TB] FAIL stop_eval_index got=%0d exp=12", buffer_index); end
    checks++; if (switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL stop_eval_pulse got=%0b exp=0", switch_pulse); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_eval_busy got=%0b exp=0", busy); end
    checks++; if (proceed !== 1'b0) begin failures++; $display("[TB] FAIL stop_eval_proceed got=%0b exp=0", proceed); end
    checks++; if (random_number !== 32'h55) begin failures++; $display("[TB] FAIL stop_eval_random got=%0h exp=55", random_number); end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL startstop_busy got=%0b exp=0", busy); end
    checks++; if (rng_ready !== 1'b0) begin failures++; $display("[TB] FAIL startstop_ready got=%0b exp=0", rng_ready); end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_fetch_stop_discard();
    go_fetch();
    rng_data  = 32'hDEAD_BEEF;
    rng_valid = 1'b1;
    stop      = 1'b1;
    tick();
    stop      = 1'b0;
    rng_valid = 1'b0;
    checks++; if (random_number !== 32'h55) begin failures++; $display("[TB] FAIL discard_random got=%0h exp=55", random_number); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL discard_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    go_fetch();
    do_commit(4'd5, 32'h0000_0077);
    checks++; if (buffer_index !== 4'd5) begin failures++; $display("[TB] FAIL pre_reset_index got=%0d exp=5", buffer_index); end
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (buffer_index !== 4'd0) begin failures++; $display("[TB] FAIL async_index got=%0d exp=0", buffer_index); end
    checks++; if (buffer_index_sync_1 !== 4'd0) begin failures++; $display("[TB] FAIL async_sync1 got=%0d exp=0", buffer_index_sync_1); end
    checks++; if (buffer_index_sync_2 !== 4'd0) begin failures++; $display("[TB] FAIL async_sync2 got=%0d exp=0", buffer_index_sync_2); end
    checks++; if (proceed !== 1'b0) begin failures++; $display("[TB] FAIL async_proceed got=%0b exp=0", proceed); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL async_busy got=%0b exp=0", busy); end
    checks++; if (random_number !== 32'd0) begin failures++; $display("[TB] FAIL async_random got=%0h exp=0", random_number); end
    #1;
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=%0b exp=0", busy); end
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    stop            = 1'b0;
    advance_req     = 1'b0;
    rng_valid       = 1'b0;
    rng_data        = 32'd0;
    tbl_next_index  = 4'd0;
    tbl_valid_count = 1'b0;
    test_reset();
    test_first_commit();
    test_history();
    test_dwell_timing();
    test_stall();
    test_stop_eval();
    test_start_stop_idle();
    test_fetch_stop_discard();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
